// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle of the bit-serial subtractor; clk and rst stay plain ports.
interface serial_sub_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: d = x - y - c, bo is the borrow out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~(x ^ y) & c);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// framed by a start/busy/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             cell_d;
  logic             cell_bo;

  full_sub u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .c  (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result bits enter at the MSB side so that after WIDTH shifts bit 0 sits at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= bus.bin;
            res_sr <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= cell_bo;
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff_q <= {cell_d, res_sr[WIDTH-1:1]};
            bout_q <= cell_bo;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: an 8-bit instance for handshake/timing scenarios
// and a 4-bit instance swept over every operand combination.
module tb_serial_sub;

  logic clk;
  logic rst;
  int   cmp;
  int   errs;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(4)) bus4 ();

  serial_sub #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation from a one-cycle start; reports what was observed.
  task automatic run_op8(
    input  logic [7:0] av,
    input  logic [7:0] bv,
    input  logic       binv,
    output logic [7:0] got_d,
    output logic       got_b,
    output int         lat,
    output int         busy_n,
    output bit         overlap,
    output bit         hold_bad,
    output logic       done_next,
    output bit         timeout
  );
    logic [7:0] held;
    held     = bus8.diff;
    overlap  = 1'b0;
    hold_bad = 1'b0;
    timeout  = 1'b1;
    busy_n   = 0;
    bus8.a     = av;
    bus8.b     = bv;
    bus8.bin   = binv;
    bus8.start = 1'b1;
    tick();
    lat = 1;
    bus8.start = 1'b0;
    bus8.a     = ~av;
    bus8.b     = ~bv;
    bus8.bin   = ~binv;
    if (bus8.busy) busy_n++;
    for (int i = 0; i < 40; i++) begin
      if (bus8.busy && bus8.done) overlap = 1'b1;
      if (bus8.busy && bus8.diff !== held) hold_bad = 1'b1;
      if (bus8.done) begin
        timeout = 1'b0;
        break;
      end
      tick();
      lat++;
      if (bus8.busy) busy_n++;
    end
    got_d = bus8.diff;
    got_b = bus8.bout;
    tick();
    done_next = bus8.done;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus4.start = 1'b0;
    tick();
    tick();
    cmp++;
    if (bus8.busy !== 1'b0) begin errs++; $display("[TB] FAIL reset_busy got %b want 0", bus8.busy); end
    cmp++;
    if (bus8.done !== 1'b0) begin errs++; $display("[TB] FAIL reset_done got %b want 0", bus8.done); end
    cmp++;
    if (bus8.diff !== 8'h00) begin errs++; $display("[TB] FAIL reset_diff got %h want 00", bus8.diff); end
    cmp++;
    if (bus8.bout !== 1'b0) begin errs++; $display("[TB] FAIL reset_bout got %b want 0", bus8.bout); end
    cmp++;
    if ({bus4.busy, bus4.done, bus4.diff, bus4.bout} !== 7'b0) begin
      errs++;
      $display("[TB] FAIL reset_w4 got %b want 0000000", {bus4.busy, bus4.done, bus4.diff, bus4.bout});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       bo, dn;
    int         lat, bn;
    bit         ov, hb, to;
    run_op8(8'h05, 8'h03, 1'b0, d, bo, lat, bn, ov, hb, dn, to);
    cmp++;
    if (to) begin errs++; $display("[TB] FAIL basic_timeout no done within bound"); end
    cmp++;
    if (d !== 8'h02) begin errs++; $display("[TB] FAIL basic_diff got %h want 02", d); end
    cmp++;
    if (bo !== 1'b0) begin errs++; $display("[TB] FAIL basic_bout got %b want 0", bo); end
    cmp++;
    if (lat !== 9) begin errs++; $display("[TB] FAIL basic_latency got %0d want 9", lat); end
    cmp++;
    if (bn !== 8) begin errs++; $display("[TB] FAIL basic_busy_cycles got %0d want 8", bn); end
    cmp++;
    if (ov) begin errs++; $display("[TB] FAIL basic_busy_done_overlap got 1 want 0"); end
    cmp++;
    if (dn !== 1'b0) begin errs++; $display("[TB] FAIL basic_done_width got %b want 0", dn); end
    cmp++;
    if (bus8.busy !== 1'b0) begin errs++; $display("[TB] FAIL basic_idle_busy got %b want 0", bus8.busy); end
  endtask

  task automatic test_borrow();
    logic [7:0] d;
    logic       bo, dn;
    int         lat, bn;
    bit         ov, hb, to;
    run_op8(8'h00, 8'h01, 1'b0, d, bo, lat, bn, ov, hb, dn, to);
    cmp++;
    if (to || d !== 8'hFF || bo !== 1'b1) begin
      errs++;
      $display("[TB] FAIL borrow_0m1 got diff=%h bout=%b timeout=%b want diff=FF bout=1", d, bo, to);
    end
    cmp++;
    if (hb) begin errs++; $display("[TB] FAIL borrow_0m1_hold diff changed while busy"); end
    run_op8(8'hFF, 8'hFF, 1'b1, d, bo, lat, bn, ov, hb, dn, to);
    cmp++;
    if (to || d !== 8'hFF || bo !== 1'b1) begin
      errs++;
      $display("[TB] FAIL borrow_ffmffm1 got diff=%h bout=%b timeout=%b want diff=FF bout=1", d, bo, to);
    end
    run_op8(8'hC8, 8'h37, 1'b1, d, bo, lat, bn, ov, hb, dn, to);
    cmp++;
    if (to || d !== 8'h90 || bo !== 1'b0) begin
      errs++;
      $display("[TB] FAIL borrow_c8m37m1 got diff=%h bout=%b timeout=%b want diff=90 bout=0", d, bo, to);
    end
  endtask

  task automatic test_ignore_start();
    bit hold_bad, seen;
    hold_bad = 1'b0;
    seen     = 1'b0;
    bus8.a     = 8'h20;
    bus8.b     = 8'h05;
    bus8.bin   = 1'b0;
    bus8.start = 1'b1;
    tick();
    bus8.a   = 8'h77;
    bus8.b   = 8'h11;
    bus8.bin = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus8.busy && bus8.diff !== 8'h90) hold_bad = 1'b1;
      if (bus8.done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    cmp++;
    if (!seen || bus8.diff !== 8'h1B || bus8.bout !== 1'b0) begin
      errs++;
      $display("[TB] FAIL ignore_result got diff=%h bout=%b done_seen=%b want diff=1B bout=0", bus8.diff, bus8.bout, seen);
    end
    cmp++;
    if (hold_bad) begin errs++; $display("[TB] FAIL ignore_hold diff changed while busy, want 90 held"); end
    tick();
    bus8.start = 1'b0;
    cmp++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      errs++;
      $display("[TB] FAIL ignore_in_done got busy=%b done=%b want 0 0", bus8.busy, bus8.done);
    end
    tick();
    cmp++;
    if (bus8.busy !== 1'b0) begin errs++; $display("[TB] FAIL ignore_not_queued got busy=%b want 0", bus8.busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d;
    logic       bo, dn;
    int         lat, bn, pulses;
    bit         ov, hb, to;
    bus8.a     = 8'h40;
    bus8.b     = 8'h01;
    bus8.bin   = 1'b0;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    cmp++;
    if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'b0) begin
      errs++;
      $display("[TB] FAIL midrst_outputs got busy=%b done=%b diff=%h bout=%b want all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done || bus8.busy) pulses++;
    end
    cmp++;
    if (pulses !== 0) begin errs++; $display("[TB] FAIL midrst_no_done got %0d active cycles want 0", pulses); end
    run_op8(8'h10, 8'h01, 1'b0, d, bo, lat, bn, ov, hb, dn, to);
    cmp++;
    if (to || d !== 8'h0F || bo !== 1'b0) begin
      errs++;
      $display("[TB] FAIL midrst_after got diff=%h bout=%b timeout=%b want diff=0F bout=0", d, bo, to);
    end
  endtask

  task automatic test_back_to_back();
    int t, n;
    int when[3];
    bit bad_d;
    n     = 0;
    t     = 0;
    bad_d = 1'b0;
    bus8.a     = 8'h09;
    bus8.b     = 8'h04;
    bus8.bin   = 1'b0;
    bus8.start = 1'b1;
    for (int i = 0; i < 60 && n < 3; i++) begin
      tick();
      t++;
      if (bus8.done) begin
        when[n] = t;
        n++;
        if (bus8.diff !== 8'h05 || bus8.bout !== 1'b0) bad_d = 1'b1;
      end
    end
    bus8.start = 1'b0;
    cmp++;
    if (n !== 3) begin
      errs++;
      $display("[TB] FAIL b2b_count got %0d pulses want 3", n);
    end else begin
      cmp++;
      if (when[0] !== 9) begin errs++; $display("[TB] FAIL b2b_first got %0d want 9", when[0]); end
      cmp++;
      if (when[1] - when[0] !== 10 || when[2] - when[1] !== 10) begin
        errs++;
        $display("[TB] FAIL b2b_spacing got %0d,%0d want 10,10", when[1] - when[0], when[2] - when[1]);
      end
    end
    cmp++;
    if (bad_d) begin errs++; $display("[TB] FAIL b2b_result diff/bout wrong, want 05/0"); end
    tick();
    tick();
  endtask

  task automatic test_sweep4();
    int e, lat;
    logic [3:0] exp_d;
    logic       exp_b;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          e     = av - bv - ci;
          exp_d = 4'(e & 15);
          exp_b = (e < 0);
          bus4.a     = 4'(av);
          bus4.b     = 4'(bv);
          bus4.bin   = ci[0];
          bus4.start = 1'b1;
          tick();
          bus4.start = 1'b0;
          lat = 1;
          for (int i = 0; i < 12; i++) begin
            if (bus4.done) break;
            tick();
            lat++;
          end
          cmp++;
          if (lat !== 5 || bus4.diff !== exp_d || bus4.bout !== exp_b) begin
            errs++;
            $display("[TB] FAIL sweep4 a=%h b=%h bin=%0d got diff=%h bout=%b lat=%0d want diff=%h bout=%b lat=5",
                     av, bv, ci, bus4.diff, bus4.bout, lat, exp_d, exp_b);
          end
          tick();
          cmp++;
          if (bus4.done !== 1'b0) begin
            errs++;
            $display("[TB] FAIL sweep4_done_width a=%h b=%h bin=%0d got done=%b want 0", av, bv, ci, bus4.done);
          end
        end
      end
    end
  endtask

  initial begin
    cmp  = 0;
    errs = 0;
    rst  = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.bin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.bin   = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
